// File: rtl/scan_chain_loader.sv
// -----------------------------------------------------------------------------
// scan_chain_loader
//
// Upstream configuration stage for the FracturableLUT scan chain. Parallel
// configuration words arrive over a valid/ready handshake. Each word is
// serialised LSB-first onto sc_data, and one sc_clk pulse is generated per
// bit. The chain samples on the rising edge of sc_clk, so sc_data is always
// changed while sc_clk is low (SETUP phase) and is held through the high
// phase (HIGH). The block counts the bits it shifts and, at the end of a load,
// compares the total with CHAIN_LEN.
//
// Optional feature (macro SC_READBACK_EN): adds a CHAIN_LEN-bit readback
// register. It captures the chain tail (sc_data_ret) on every sc_clk rise. The
// default build, with the macro undefined, leaves out the port and its logic,
// and sc_data_ret is ignored.
//
// Parameters
//   WORD_W     parallel configuration word width
//   CHAIN_LEN  expected total chain length in bits
//   CLK_DIV    clk cycles per sc_clk phase (>= 1); one bit takes 2*CLK_DIV
//   CNT_W      width of bit_count
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset (0 = reset asserted)
//   cfg_valid    source has a word available
//   cfg_ready    loader accepts a word in this cycle
//   cfg_data     configuration bits; bit 0 is shifted first
//   cfg_len      number of valid bits in the word; 0 (or > WORD_W) = WORD_W
//   cfg_last     marks the final word of the load
//   sc_clk       scan-chain shift clock (registered)
//   sc_data      scan-chain serial data (registered)
//   sc_data_ret  chain tail return (used only with SC_READBACK_EN)
//   busy         a load is in progress
//   done         one-cycle pulse at the end of a load
//   length_err   total bits != CHAIN_LEN at the end of the last load (sticky)
//   bit_count    bits shifted in the current or last load, saturating
//   readback     previous chain contents (SC_READBACK_EN only)
//   fsm_state    current FSM state, exported for observation
//
// Handshake: a word transfers on a rising clk edge where cfg_valid and
// cfg_ready are both 1. cfg_ready depends only on the FSM state, never on
// cfg_valid. While cfg_valid is high and no transfer has happened, the source
// must hold cfg_data, cfg_len and cfg_last stable.
// -----------------------------------------------------------------------------
module scan_chain_loader #(
  parameter int WORD_W    = 16,
  parameter int CHAIN_LEN = 17,
  parameter int CLK_DIV   = 1,
  parameter int CNT_W     = 16,
  localparam int LEN_W    = $clog2(WORD_W + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [WORD_W-1:0]    cfg_data,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic                 cfg_last,
  output logic                 sc_clk,
  output logic                 sc_data,
  input  logic                 sc_data_ret,
  output logic                 busy,
  output logic                 done,
  output logic                 length_err,
  output logic [CNT_W-1:0]     bit_count,
`ifdef SC_READBACK_EN
  output logic [CHAIN_LEN-1:0] readback,
`endif
  output logic [2:0]           fsm_state
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_FETCH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state;
  state_t             next_state;

  logic [DIV_W-1:0]   div_cnt;     // cycles spent in the current sc_clk phase
  logic               phase_end;   // last cycle of a SETUP/HIGH phase
  logic [WORD_W-1:0]  shreg;       // bit 0 is the bit currently on sc_data
  logic [WORD_W-1:0]  shreg_next;
  logic [LEN_W-1:0]   bits_left;   // bits of the word not yet clocked, incl. current
  logic [LEN_W-1:0]   eff_len;
  logic               last_q;
  logic               ready_en;    // keeps cfg_ready low while reset is asserted
  logic               take;        // handshake completes this cycle

  // cfg_len of 0 means a full word, and lengths beyond the word are clamped.
  assign eff_len    = (cfg_len == '0 || cfg_len > LEN_W'(WORD_W)) ? LEN_W'(WORD_W) : cfg_len;
  assign shreg_next = shreg >> 1;
  assign phase_end  = (div_cnt == DIV_W'(CLK_DIV - 1));

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic and state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    cfg_ready  = 1'b0;
    take       = 1'b0;
    case (state)
      S_IDLE: begin
        cfg_ready = ready_en;
        if (cfg_valid && ready_en) begin
          take       = 1'b1;
          next_state = S_SETUP;
        end
      end
      S_SETUP: begin
        if (phase_end) next_state = S_HIGH;
      end
      S_HIGH: begin
        if (phase_end) begin
          if (bits_left > LEN_W'(1)) next_state = S_SETUP;
          else if (last_q)           next_state = S_DONE;
          else                       next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          take       = 1'b1;
          next_state = S_SETUP;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign fsm_state = state;

  // ---------------------------------------------------------------------------
  // Datapath: phase timer, word shifter, sc_clk/sc_data, bit counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en   <= 1'b0;
      div_cnt    <= '0;
      shreg      <= '0;
      bits_left  <= '0;
      last_q     <= 1'b0;
      sc_clk     <= 1'b0;
      sc_data    <= 1'b0;
      bit_count  <= '0;
      length_err <= 1'b0;
    end else begin
      ready_en <= 1'b1;

      // The timer restarts on every state change, so each SETUP or HIGH
      // phase lasts exactly CLK_DIV cycles.
      if (next_state != state) begin
        div_cnt <= '0;
      end else if (state == S_SETUP || state == S_HIGH) begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      // Accepting a word drives its first bit straight away, while sc_clk is
      // low. A new load, accepted from IDLE, also restarts the counters.
      if (take) begin
        shreg     <= cfg_data;
        bits_left <= eff_len;
        last_q    <= cfg_last;
        sc_data   <= cfg_data[0];
        sc_clk    <= 1'b0;
        if (state == S_IDLE) begin
          bit_count  <= '0;
          length_err <= 1'b0;
        end
      end

      // Rising edge of sc_clk: the bit is counted here.
      if (state == S_SETUP && next_state == S_HIGH) begin
        sc_clk <= 1'b1;
        if (bit_count != {CNT_W{1'b1}}) begin
          bit_count <= bit_count + CNT_W'(1);
        end
      end

      // Falling edge of sc_clk. The next bit is presented together with the
      // fall, so it has a full low phase of setup before the next rise. When
      // FETCH follows, sc_data keeps the last bit of the word.
      if (state == S_HIGH && next_state != S_HIGH) begin
        sc_clk <= 1'b0;
        if (next_state == S_SETUP) begin
          shreg     <= shreg_next;
          sc_data   <= shreg_next[0];
          bits_left <= bits_left - LEN_W'(1);
        end
        // bit_count already holds its final value here, so the error flag is
        // valid in the same cycle as done.
        if (next_state == S_DONE) begin
          length_err <= (int'(bit_count) != CHAIN_LEN);
        end
      end
    end
  end

`ifdef SC_READBACK_EN
  // ---------------------------------------------------------------------------
  // Readback: the chain tail shifts in from the MSB on every sc_clk rise.
  // After a full reload, bit 0 holds the first bit of the previous load.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readback <= '0;
    end else if (state == S_SETUP && next_state == S_HIGH) begin
      readback <= {sc_data_ret, readback[CHAIN_LEN-1:1]};
    end
  end
`else
  logic unused_ret;
  assign unused_ret = sc_data_ret;
`endif

endmodule

// File: tb/tb_scan_chain_loader.sv
`timescale 1ns/1ps
module tb_scan_chain_loader;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic reset = 1'b1;

  int total = 0;
  int bad   = 0;

  // ---------------------------------------------------------------------------
  // DUT 1: default parameters (CLK_DIV=1, CNT_W=16)
  // ---------------------------------------------------------------------------
  logic        cfg_valid = 1'b0;
  logic [15:0] cfg_data  = '0;
  logic [4:0]  cfg_len   = '0;
  logic        cfg_last  = 1'b0;
  logic        cfg_ready, sc_clk, sc_data, sc_data_ret, busy, done, length_err;
  logic [15:0] bit_count;
  logic [2:0]  fsm_state;
`ifdef SC_READBACK_EN
  logic [16:0] readback;
`endif

  scan_chain_loader #(.WORD_W(16), .CHAIN_LEN(17), .CLK_DIV(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .cfg_len(cfg_len), .cfg_last(cfg_last),
    .sc_clk(sc_clk), .sc_data(sc_data), .sc_data_ret(sc_data_ret),
    .busy(busy), .done(done), .length_err(length_err), .bit_count(bit_count),
`ifdef SC_READBACK_EN
    .readback(readback),
`endif
    .fsm_state(fsm_state)
  );

  // Downstream 17-bit chain (16 LUT bits + fracture bit): each rise shifts
  // right and the new bit enters at the MSB, so bit 0 holds the first bit sent.
  logic [16:0] chain1 = '0;
  always @(posedge sc_clk) chain1 <= {sc_data, chain1[16:1]};
  assign sc_data_ret = chain1[0];

  // ---------------------------------------------------------------------------
  // DUT 3: CLK_DIV=3 with a 3-bit saturating counter
  // ---------------------------------------------------------------------------
  logic        d3_cfg_valid = 1'b0;
  logic [15:0] d3_cfg_data  = '0;
  logic [4:0]  d3_cfg_len   = '0;
  logic        d3_cfg_last  = 1'b0;
  logic        d3_sc_data_ret = 1'b0;
  logic        d3_cfg_ready, d3_sc_clk, d3_sc_data, d3_busy, d3_done, d3_length_err;
  logic [2:0]  d3_bit_count;
  logic [2:0]  d3_fsm_state;
`ifdef SC_READBACK_EN
  logic [16:0] d3_readback;
`endif

  scan_chain_loader #(.WORD_W(16), .CHAIN_LEN(17), .CLK_DIV(3), .CNT_W(3)) dut3 (
    .clk(clk), .reset(reset),
    .cfg_valid(d3_cfg_valid), .cfg_ready(d3_cfg_ready), .cfg_data(d3_cfg_data),
    .cfg_len(d3_cfg_len), .cfg_last(d3_cfg_last),
    .sc_clk(d3_sc_clk), .sc_data(d3_sc_data), .sc_data_ret(d3_sc_data_ret),
    .busy(d3_busy), .done(d3_done), .length_err(d3_length_err), .bit_count(d3_bit_count),
`ifdef SC_READBACK_EN
    .readback(d3_readback),
`endif
    .fsm_state(d3_fsm_state)
  );

  // ---------------------------------------------------------------------------
  // Monitors: record the bit at each sc_clk rise and flag data changes
  // while sc_clk is high (or coincident with the rise).
  // ---------------------------------------------------------------------------
  logic [0:0] obs_q[$];
  int         rise_q[$];
  int         setup_viol = 0;
  logic       prev_clk = 1'b0, prev_data = 1'b0;

  always @(negedge clk) begin
    if (sc_clk === 1'b1 && prev_clk === 1'b0) begin
      obs_q.push_back(sc_data);
      rise_q.push_back(cyc);
    end
    if (sc_clk === 1'b1 && sc_data !== prev_data) setup_viol <= setup_viol + 1;
    prev_clk  <= sc_clk;
    prev_data <= sc_data;
  end

  logic [0:0] d3_obs_q[$];
  int         d3_rise_q[$];
  int         d3_setup_viol = 0;
  int         d3_phase_viol = 0;
  int         d3_hi_run = 0;
  int         d3_busy_cyc = 0;
  logic       d3_prev_clk = 1'b0, d3_prev_data = 1'b0;

  always @(negedge clk) begin
    if (d3_sc_clk === 1'b1 && d3_prev_clk === 1'b0) begin
      d3_obs_q.push_back(d3_sc_data);
      d3_rise_q.push_back(cyc);
    end
    if (d3_sc_clk === 1'b1 && d3_sc_data !== d3_prev_data) d3_setup_viol <= d3_setup_viol + 1;
    if (d3_sc_clk === 1'b1) begin
      d3_hi_run <= d3_hi_run + 1;
    end else begin
      if (d3_prev_clk === 1'b1 && d3_hi_run != 3) d3_phase_viol <= d3_phase_viol + 1;
      d3_hi_run <= 0;
    end
    if (d3_busy === 1'b1 && d3_done === 1'b0) d3_busy_cyc <= d3_busy_cyc + 1;
    d3_prev_clk  <= d3_sc_clk;
    d3_prev_data <= d3_sc_data;
  end

  // ---------------------------------------------------------------------------
  // Reference model: the bit stream is every word's effective bits, LSB
  // first, concatenated. The load length is the sum of the effective lengths.
  // ---------------------------------------------------------------------------
  logic [0:0] exp_q[$];
  int         exp_n = 0;

  function automatic void model_word(input logic [15:0] d, input logic [4:0] l);
    int n;
    n = (l == 0 || l > 16) ? 16 : int'(l);
    for (int i = 0; i < n; i++) exp_q.push_back(d[i]);
    exp_n += n;
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    exp_n = 0;
  endfunction

  function automatic logic [63:0] pack_exp();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < exp_q.size() && i < 64; i++) v[i] = exp_q[i];
    return v;
  endfunction

  function automatic logic [63:0] pack_obs();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < obs_q.size() && i < 64; i++) v[i] = obs_q[i];
    return v;
  endfunction

  function automatic logic [63:0] pack_obs3();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < d3_obs_q.size() && i < 64; i++) v[i] = d3_obs_q[i];
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  int last_hs_cyc = 0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [15:0] d, input logic [4:0] l, input logic last);
    int waited;
    waited = 0;
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_len   = l;
    cfg_last  = last;
    while (cfg_ready !== 1'b1 && waited < 2000) begin
      tick();
      waited++;
    end
    if (cfg_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL handshake_timeout: cfg_ready=%b after %0d cycles, required 1", cfg_ready, waited);
    end
    last_hs_cyc = cyc;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic drive_word3(input logic [15:0] d, input logic [4:0] l, input logic last);
    int waited;
    waited = 0;
    d3_cfg_valid = 1'b1;
    d3_cfg_data  = d;
    d3_cfg_len   = l;
    d3_cfg_last  = last;
    while (d3_cfg_ready !== 1'b1 && waited < 2000) begin
      tick();
      waited++;
    end
    if (d3_cfg_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL d3_handshake_timeout: cfg_ready=%b after %0d cycles, required 1", d3_cfg_ready, waited);
    end
    last_hs_cyc = cyc;
    tick();
    d3_cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, output bit ok);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    total++;
    ok = (done === 1'b1);
    if (!ok) begin
      bad++;
      $display("FAIL %s_done_timeout: done=%b, required 1", name, done);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0;
    cfg_valid = 1'b1; cfg_data = 16'hFFFF;
    d3_cfg_valid = 1'b1; d3_cfg_data = 16'hFFFF;
    repeat (3) tick();
    total++;
    if ({cfg_ready, sc_clk, sc_data, busy, done, length_err} !== 6'b0 || bit_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_outputs: rdy=%b sck=%b sd=%b busy=%b done=%b err=%b cnt=%0d, required all 0",
               cfg_ready, sc_clk, sc_data, busy, done, length_err, bit_count);
    end
    total++;
    if ({d3_cfg_ready, d3_sc_clk, d3_sc_data, d3_busy, d3_done, d3_length_err} !== 6'b0 || d3_bit_count !== 3'd0) begin
      bad++;
      $display("FAIL reset_outputs_d3: rdy=%b sck=%b busy=%b cnt=%0d, required all 0",
               d3_cfg_ready, d3_sc_clk, d3_busy, d3_bit_count);
    end
    cfg_valid = 1'b0; d3_cfg_valid = 1'b0;
    reset = 1'b1;
    tick();
    total++;
    if (cfg_ready !== 1'b1 || sc_clk !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: rdy=%b sck=%b busy=%b, required 1/0/0", cfg_ready, sc_clk, busy);
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++;
      $display("FAIL reset_no_edge: %0d sc_clk rises, required 0", obs_q.size());
    end
  endtask

  task automatic test_nominal();
    bit ok;
    int hs0, gap_bad;
    model_clear(); obs_q.delete(); rise_q.delete();
    gap_bad = 0;
    model_word(16'hA5C3, 5'd0);
    model_word(16'h0001, 5'd1);
    drive_word(16'hA5C3, 5'd0, 1'b0);
    hs0 = last_hs_cyc;
    drive_word(16'h0001, 5'd1, 1'b1);
    wait_done("nominal", ok);
    if (ok) begin
      total++;
      if (bit_count !== 16'd17 || length_err !== 1'b0) begin
        bad++;
        $display("FAIL nominal_count: cnt=%0d err=%b, required 17/0", bit_count, length_err);
      end
      tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
        bad++;
        $display("FAIL nominal_done_pulse: done=%b busy=%b rdy=%b, required 0/0/1", done, busy, cfg_ready);
      end
      total++;
      if (obs_q.size() != exp_q.size() || pack_obs() !== pack_exp()) begin
        bad++;
        $display("FAIL nominal_bits: got %0d bits %h, required %0d bits %h",
                 obs_q.size(), pack_obs(), exp_q.size(), pack_exp());
      end
      total++;
      if (chain1[15:0] !== 16'hA5C3 || chain1[16] !== 1'b1) begin
        bad++;
        $display("FAIL nominal_lut: lut=%h frac=%b, required a5c3/1", chain1[15:0], chain1[16]);
      end
      // The handshake cycle plus CLK_DIV cycles of SETUP come before the first rise.
      total++;
      if (rise_q.size() == 0 || rise_q[0] - hs0 != 2) begin
        bad++;
        $display("FAIL nominal_latency: %0d cycles, required 2", rise_q.size() ? rise_q[0] - hs0 : -1);
      end
      for (int i = 1; i < rise_q.size(); i++)
        if (rise_q[i] - rise_q[i-1] != ((i == 16) ? 3 : 2)) gap_bad++;
      total++;
      if (gap_bad != 0 || rise_q.size() != 17) begin
        bad++;
        $display("FAIL nominal_spacing: %0d bad gaps over %0d rises, required 0 over 17", gap_bad, rise_q.size());
      end
    end
    total++;
    if (setup_viol != 0) begin
      bad++;
      $display("FAIL setup_discipline: %0d changes while sc_clk high, required 0", setup_viol);
    end
  endtask

  task automatic test_length_err();
    bit ok;
    model_clear(); obs_q.delete();
    model_word(16'h00FF, 5'd8);
    drive_word(16'h00FF, 5'd8, 1'b1);
    wait_done("lenerr", ok);
    if (ok) begin
      total++;
      if (bit_count !== 16'd8 || length_err !== 1'b1) begin
        bad++;
        $display("FAIL lenerr_flag: cnt=%0d err=%b, required 8/1", bit_count, length_err);
      end
      total++;
      if (obs_q.size() != 8 || pack_obs() !== pack_exp()) begin
        bad++;
        $display("FAIL lenerr_bits: got %0d bits %h, required 8 bits %h", obs_q.size(), pack_obs(), pack_exp());
      end
    end
    repeat (3) tick();
    total++;
    if (length_err !== 1'b1) begin
      bad++;
      $display("FAIL lenerr_sticky: err=%b, required 1", length_err);
    end
    drive_word(16'h1234, 5'd0, 1'b0);
    total++;
    if (length_err !== 1'b0 || bit_count !== 16'd0) begin
      bad++;
      $display("FAIL lenerr_clear: err=%b cnt=%0d, required 0/0", length_err, bit_count);
    end
    drive_word(16'h0000, 5'd1, 1'b1);
    wait_done("lenerr_reload", ok);
    total++;
    if (length_err !== 1'b0 || bit_count !== 16'd17) begin
      bad++;
      $display("FAIL lenerr_reload: err=%b cnt=%0d, required 0/17", length_err, bit_count);
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [15:0] d1, d2;
    logic held;
    int n, stall_bad, rises;
    d1 = 16'($urandom);
    d2 = 16'($urandom_range(0, 1));
    model_clear(); obs_q.delete();
    model_word(d1, 5'd0);
    model_word(d2, 5'd1);
    drive_word(d1, 5'd0, 1'b0);
    n = 0;
    while (!(busy === 1'b1 && cfg_ready === 1'b1) && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (!(busy === 1'b1 && cfg_ready === 1'b1)) begin
      bad++;
      $display("FAIL stall_fetch_timeout: busy=%b rdy=%b, required 1/1", busy, cfg_ready);
    end
    held = sc_data;
    rises = obs_q.size();
    stall_bad = 0;
    repeat (10) begin
      if (sc_clk !== 1'b0 || sc_data !== held || cfg_ready !== 1'b1) stall_bad++;
      tick();
    end
    total++;
    if (stall_bad != 0 || obs_q.size() != rises) begin
      bad++;
      $display("FAIL stall_hold: %0d bad cycles, %0d extra rises, required 0/0", stall_bad, obs_q.size() - rises);
    end
    drive_word(d2, 5'd1, 1'b1);
    wait_done("stall", ok);
    if (ok) begin
      total++;
      if (obs_q.size() != exp_q.size() || pack_obs() !== pack_exp() || bit_count !== 16'd17 || length_err !== 1'b0) begin
        bad++;
        $display("FAIL stall_bits: got %0d bits %h cnt=%0d err=%b, required %0d bits %h cnt=17 err=0",
                 obs_q.size(), pack_obs(), bit_count, length_err, exp_q.size(), pack_exp());
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int nw;
    logic [15:0] d;
    logic [4:0] l;
    for (int it = 0; it < 6; it++) begin
      model_clear(); obs_q.delete();
      nw = (it == 0) ? 2 : $urandom_range(1, 3);
      for (int w = 0; w < nw; w++) begin
        d = 16'($urandom);
        l = (it == 0) ? ((w == 0) ? 5'd0 : 5'd1) : 5'($urandom_range(0, 31));
        model_word(d, l);
        if (w > 0 && $urandom_range(0, 1) == 1) repeat ($urandom_range(1, 6)) tick();
        drive_word(d, l, (w == nw - 1));
      end
      wait_done("random", ok);
      if (ok) begin
        total++;
        if (obs_q.size() != exp_q.size() || pack_obs() !== pack_exp()) begin
          bad++;
          $display("FAIL random_bits[%0d]: got %0d bits %h, required %0d bits %h",
                   it, obs_q.size(), pack_obs(), exp_q.size(), pack_exp());
        end
        total++;
        if (int'(bit_count) != exp_n || length_err !== (exp_n != 17)) begin
          bad++;
          $display("FAIL random_count[%0d]: cnt=%0d err=%b, required %0d/%b",
                   it, bit_count, length_err, exp_n, (exp_n != 17));
        end
      end
    end
  endtask

  task automatic test_clock_divide();
    int n, hs0, busy0, gap_bad;
    model_clear(); d3_obs_q.delete(); d3_rise_q.delete();
    gap_bad = 0;
    busy0 = d3_busy_cyc;
    model_word(16'hA5C3, 5'd0);
    model_word(16'h0001, 5'd1);
    drive_word3(16'hA5C3, 5'd0, 1'b0);
    hs0 = last_hs_cyc;
    drive_word3(16'h0001, 5'd1, 1'b1);
    n = 0;
    while (d3_done !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    total++;
    if (d3_done !== 1'b1) begin
      bad++;
      $display("FAIL div3_done_timeout: done=%b, required 1", d3_done);
    end else begin
      total++;
      if (d3_obs_q.size() != exp_q.size() || pack_obs3() !== pack_exp()) begin
        bad++;
        $display("FAIL div3_bits: got %0d bits %h, required %0d bits %h",
                 d3_obs_q.size(), pack_obs3(), exp_q.size(), pack_exp());
      end
      // 17 bits saturate a 3-bit counter at 7, and 7 != 17.
      total++;
      if (d3_bit_count !== 3'd7 || d3_length_err !== 1'b1) begin
        bad++;
        $display("FAIL div3_saturate: cnt=%0d err=%b, required 7/1", d3_bit_count, d3_length_err);
      end
      total++;
      if (d3_busy_cyc - busy0 != 103) begin
        bad++;
        $display("FAIL div3_duration: %0d shift cycles, required 103", d3_busy_cyc - busy0);
      end
      total++;
      if (d3_rise_q.size() == 0 || d3_rise_q[0] - hs0 != 4) begin
        bad++;
        $display("FAIL div3_latency: %0d cycles, required 4", d3_rise_q.size() ? d3_rise_q[0] - hs0 : -1);
      end
      for (int i = 1; i < d3_rise_q.size(); i++)
        if (d3_rise_q[i] - d3_rise_q[i-1] != ((i == 16) ? 7 : 6)) gap_bad++;
      total++;
      if (gap_bad != 0 || d3_phase_viol != 0 || d3_setup_viol != 0) begin
        bad++;
        $display("FAIL div3_phases: gaps=%0d high_runs=%0d setup=%0d, required 0/0/0",
                 gap_bad, d3_phase_viol, d3_setup_viol);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    int n, rises;
    obs_q.delete();
    drive_word(16'hA5C3, 5'd0, 1'b0);
    n = 0;
    while (obs_q.size() < 5 && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (obs_q.size() < 5) begin
      bad++;
      $display("FAIL midreset_rises: %0d rises, required 5", obs_q.size());
    end
    reset = 1'b0;
    #1;
    total++;
    if (sc_clk !== 1'b0 || bit_count !== 16'd0 || busy !== 1'b0 || cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL midreset_state: sck=%b cnt=%0d busy=%b rdy=%b, required 0/0/0/0",
               sc_clk, bit_count, busy, cfg_ready);
    end
    rises = obs_q.size();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    total++;
    if (obs_q.size() != rises || cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset_release: %0d extra rises rdy=%b, required 0/1", obs_q.size() - rises, cfg_ready);
    end
    model_clear(); obs_q.delete();
    model_word(16'hA5C3, 5'd0);
    model_word(16'h0001, 5'd1);
    drive_word(16'hA5C3, 5'd0, 1'b0);
    drive_word(16'h0001, 5'd1, 1'b1);
    wait_done("midreset_reload", ok);
    if (ok) begin
      total++;
      if (pack_obs() !== pack_exp() || obs_q.size() != 17 || bit_count !== 16'd17 || chain1 !== 17'h1A5C3) begin
        bad++;
        $display("FAIL midreset_reload: bits=%h cnt=%0d chain=%h, required %h/17/1a5c3",
                 pack_obs(), bit_count, chain1, pack_exp());
      end
    end
    tick();
  endtask

`ifdef SC_READBACK_EN
  task automatic test_readback();
    bit ok;
    for (int k = 0; k < 2; k++) begin
      drive_word(16'hA5C3, 5'd0, 1'b0);
      drive_word(16'h0001, 5'd1, 1'b1);
      wait_done("readback", ok);
      tick();
    end
    total++;
    if (readback !== 17'h1A5C3) begin
      bad++;
      $display("FAIL readback_value: readback=%h, required 1a5c3", readback);
    end
  endtask
`endif

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_nominal();
    test_length_err();
    test_stall();
    test_random();
    test_clock_divide();
    test_reset_mid_load();
`ifdef SC_READBACK_EN
    test_readback();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded 500000 ns");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/scan_chain_loader.md
Name: scan_chain_loader

Overview:
- Upstream configuration stage for the FracturableLUT scan chain.
- Accepts parallel configuration words over a valid/ready handshake, serialises them LSB-first and generates sc_clk/sc_data with the chain's setup discipline: data is driven while sc_clk is low, then sc_clk rises.
- Counts shifted bits, checks the total against the expected chain length, and signals completion.

Parameters:
- WORD_W, 16, parallel config word width.
- CHAIN_LEN, 17, expected total chain bits (16 LUT bits plus 1 fracture bit).
- CLK_DIV, 1, clk cycles per sc_clk phase (≥1); one bit takes 2*CLK_DIV cycles.
- CNT_W, 16, width of bit_count.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- cfg_valid  in  1  word available.
- cfg_ready  out  1  loader accepts a word this cycle.
- cfg_data  in  WORD_W  config bits; bit 0 is shifted first.
- cfg_len  in  $clog2(WORD_W+1)  valid bits in the word; 0 means WORD_W.
- cfg_last  in  1  final word of the load.
- sc_clk  out  1  scan-chain shift clock (registered).
- sc_data  out  1  scan-chain serial data (registered).
- sc_data_ret  in  1  chain tail return (sc_data_out of the last element).
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse at end of load.
- length_err  out  1  total bits != CHAIN_LEN at end of load.
- bit_count  out  CNT_W  bits shifted in the current/last load, saturating.

Behaviour:
- Reset (async, while reset=0): FSM→IDLE; sc_clk=0, sc_data=0, cfg_ready=0, busy=0, done=0, length_err=0, bit_count=0; any partial word is discarded. A mid-shift reset may truncate the chain contents; no sc_clk rising edge is generated by reset.
- States: IDLE, SETUP, HIGH, FETCH, DONE.
- IDLE: cfg_ready=1. On cfg_valid&cfg_ready, latch data/len/last, clear bit_count and length_err, then go to SETUP.
- SETUP: sc_clk=0; sc_data=current bit (driven on entry); hold CLK_DIV cycles, then go to HIGH.
- HIGH: sc_clk=1 for CLK_DIV cycles; bit_count increments on entry (saturates at 2^CNT_W-1). Leaving HIGH: more bits in word→SETUP; word exhausted and !last→FETCH; word exhausted and last→DONE.
- FETCH: sc_clk=0, sc_data holds; cfg_ready=1; stalls indefinitely. On handshake, latch the new word and go to SETUP.
- DONE: done=1 for exactly one cycle; length_err set (sticky until next load starts) if bit_count != CHAIN_LEN; go to IDLE.
- busy=1 in SETUP/HIGH/FETCH/DONE.
- cfg_ready=0 in SETUP/HIGH/DONE; cfg_valid there is ignored and the word must be held by the source.
- Latency: handshake→first sc_clk rise = 1+CLK_DIV cycles. Consecutive words with cfg_valid already high add 1 FETCH cycle between bits.
- cfg_len > WORD_W is treated as WORD_W.
- sc_data_ret is unused unless SC_READBACK_EN is defined.

Optional Feature:
- Macro SC_READBACK_EN.
- Defined: adds output readback [CHAIN_LEN-1:0]. On every sc_clk rise, the register shifts right and sc_data_ret is captured into the MSB. After a full reload it holds the previous chain contents, bit 0 = first bit originally loaded. It is reset to 0 and is not cleared at load start.
- Undefined: the port and its logic are absent, and sc_data_ret is ignored.

Test Plan:
- Reset values: hold reset=0 -> all outputs 0. Release -> cfg_ready=1 next cycle, no sc_clk edge.
- Nominal load (CLK_DIV=1): send 0xA5C3 len=0 last=0, then 0x1 len=1 last=1 -> sc_data on 17 rising edges = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1,1. Then done pulses once, bit_count=17, length_err=0, and a downstream 16-entry LUT stores 0xA5C3 with fractured=1.
- Length error: single word 0x00FF len=8 last=1 -> 8 rising edges, done=1, bit_count=8, length_err=1. A following correct load clears it.
- Stall: delay the second word 10 cycles after FETCH entry -> sc_clk stays 0, sc_data stable, cfg_ready=1 throughout; the sequence completes correctly.
- Clock divide (CLK_DIV=3): sc_clk low 3 / high 3 cycles per bit; sc_data only changes while sc_clk=0; a 17-bit load takes 102 shift cycles plus 1 FETCH cycle.
- Reset mid-load: assert reset after the 5th rise -> immediate IDLE, sc_clk=0, bit_count=0. A new load then runs normally. With SC_READBACK_EN, loading 0xA5C3/1 twice makes readback=17'h1A5C3 after the second load.
